// File: rtl/tcpc_pkg.sv
// Shared Type-C Port Controller protocol-layer definitions.
// State codes are common to the rx/tx FSMs and the stimulus generator.
package tcpc_pkg;

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] TX_DISCARD   = 2'd1;
  localparam logic [1:0] SEND_GOODCRC = 2'd2;
  localparam logic [1:0] REPORT_SOP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE         = IDLE,
    ST_TX_DISCARD   = TX_DISCARD,
    ST_SEND_GOODCRC = SEND_GOODCRC,
    ST_REPORT_SOP   = REPORT_SOP
  } rx_state_t;

endpackage

// File: rtl/tcpc_rx.sv
// Receive-side protocol-layer FSM: discards colliding transmissions, requests
// a GoodCRC from the PHY and reports successful SOP reception to ALERT.
module tcpc_rx
  import tcpc_pkg::*;
(
  input  logic clk,
  input  logic reset_L,
  input  logic tx,
  input  logic message_received_from_phy,
  input  logic Unexpected_GoodCRC_received,
  input  logic GoodCRC_Transmission_complete,
  input  logic GoodCRC_Message_discarded_bus_Idle,
  output logic Send_GoodCRC_message_to_PHY,
  output logic ALERT_TxMessageDiscarded,
  output logic ALERT_ReceiveSOPStatusAsserted,
  output logic idle
);

  rx_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!reset_L) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        // An unexpected GoodCRC is dropped silently, regardless of tx.
        if (message_received_from_phy && !Unexpected_GoodCRC_received)
          state_nxt = tx ? ST_TX_DISCARD : ST_SEND_GOODCRC;
      end
      ST_TX_DISCARD: state_nxt = ST_SEND_GOODCRC;
      ST_SEND_GOODCRC: begin
        // Completion wins over a simultaneous bus-idle discard.
        if (GoodCRC_Transmission_complete)
          state_nxt = ST_REPORT_SOP;
        else if (GoodCRC_Message_discarded_bus_Idle)
          state_nxt = ST_IDLE;
      end
      ST_REPORT_SOP: state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    idle                           = 1'b0;
    ALERT_TxMessageDiscarded       = 1'b0;
    Send_GoodCRC_message_to_PHY    = 1'b0;
    ALERT_ReceiveSOPStatusAsserted = 1'b0;
    case (state)
      ST_IDLE:         idle                           = 1'b1;
      ST_TX_DISCARD:   ALERT_TxMessageDiscarded       = 1'b1;
      ST_SEND_GOODCRC: Send_GoodCRC_message_to_PHY    = 1'b1;
      ST_REPORT_SOP:   ALERT_ReceiveSOPStatusAsserted = 1'b1;
      default:         idle                           = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_tcpc_rx.sv
// Directed and randomized bench for tcpc_rx against a transaction-level
// reference model built from pending-event flags.
module tb_tcpc_rx;

  logic clk = 1'b0;
  logic reset_L, tx, msg, unexp, complete, discarded;
  logic send_crc, alert_disc, alert_sop, idle;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: what the receiver owes the world next cycle.
  bit owe_discard, owe_crc, owe_report;

  always #5 clk = ~clk;

  tcpc_rx dut (
    .clk                                (clk),
    .reset_L                            (reset_L),
    .tx                                 (tx),
    .message_received_from_phy          (msg),
    .Unexpected_GoodCRC_received        (unexp),
    .GoodCRC_Transmission_complete      (complete),
    .GoodCRC_Message_discarded_bus_Idle (discarded),
    .Send_GoodCRC_message_to_PHY        (send_crc),
    .ALERT_TxMessageDiscarded           (alert_disc),
    .ALERT_ReceiveSOPStatusAsserted     (alert_sop),
    .idle                               (idle)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!reset_L) begin
      owe_discard = 0; owe_crc = 0; owe_report = 0;
    end else if (owe_report) begin
      owe_report = 0;
    end else if (owe_discard) begin
      owe_discard = 0; owe_crc = 1;
    end else if (owe_crc) begin
      if (complete) begin
        owe_crc = 0; owe_report = 1;
      end else if (discarded) begin
        owe_crc = 0;
      end
    end else if (msg && !unexp) begin
      if (tx) owe_discard = 1;
      else    owe_crc = 1;
    end
  endtask

  task automatic step(input logic rl, input logic t, input logic m, input logic u,
                      input logic c, input logic d);
    reset_L = rl; tx = t; msg = m; unexp = u; complete = c; discarded = d;
    @(posedge clk);
    model_edge();
    #1;
    check("idle",     idle,       !(owe_discard || owe_crc || owe_report));
    check("tx_disc",  alert_disc, owe_discard);
    check("send_crc", send_crc,   owe_crc);
    check("sop",      alert_sop,  owe_report);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    owe_discard = 0; owe_crc = 0; owe_report = 0;
    reset_L = 0; tx = 0; msg = 0; unexp = 0; complete = 0; discarded = 0;

    // Reset for two cycles under random inputs.
    for (int i = 0; i < 2; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check("rst_idle", idle, 1'b1);
    check("rst_send", send_crc, 1'b0);
    quiet(3);

    // Nominal receive, tx=0.
    step(1, 0, 1, 0, 0, 0);
    check("nom_send_lat1", send_crc, 1'b1);
    quiet(2);
    check("nom_send_held", send_crc, 1'b1);
    step(1, 0, 0, 0, 1, 0);
    check("nom_sop", alert_sop, 1'b1);
    quiet(1);
    check("nom_idle_back", idle, 1'b1);
    check("nom_sop_once", alert_sop, 1'b0);

    // Collision with an outgoing message.
    step(1, 1, 1, 0, 0, 0);
    check("col_disc", alert_disc, 1'b1);
    check("col_no_send", send_crc, 1'b0);
    step(1, 1, 0, 0, 1, 1);
    check("col_disc_once", alert_disc, 1'b0);
    check("col_send_lat2", send_crc, 1'b1);
    step(1, 0, 0, 0, 1, 0);
    check("col_sop", alert_sop, 1'b1);
    quiet(1);

    // Bus idle drops the GoodCRC without a report.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    check("busidle_idle", idle, 1'b1);
    check("busidle_nosop", alert_sop, 1'b0);
    quiet(1);

    // Both completion inputs: report path wins.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1);
    check("both_sop", alert_sop, 1'b1);
    quiet(1);

    // Unexpected GoodCRC is silently dropped.
    step(1, 1, 1, 1, 0, 0);
    check("unexp_idle", idle, 1'b1);
    check("unexp_nodisc", alert_disc, 1'b0);
    step(1, 0, 1, 1, 0, 0);
    check("unexp_nosend", send_crc, 1'b0);

    // Reset in the middle of a transaction.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    check("midrst_idle", idle, 1'b1);
    check("midrst_send", send_crc, 1'b0);
    quiet(1);

    // Held message restarts a transaction right after returning to IDLE.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    check("held_back_idle", idle, 1'b1);
    step(1, 0, 1, 0, 0, 0);
    check("held_restart", send_crc, 1'b1);
    step(1, 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 39) != 0), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
